// File: rtl/io_resp.sv
// I/O-bus responder: GPIO, millisecond tick timer with compare flag,
// character FIFO for the video text display, and a device ID register.
module io_resp #(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned FIFO_AW  = 3,
    parameter logic [15:0] DEV_ID   = 16'h7D41
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [7:0]  ioad,
    input  logic [15:0] iowdt,
    input  logic        ior,
    input  logic        iow,
    output logic [15:0] iordt,
    input  logic [15:0] gpio_in,
    output logic [15:0] gpio_out,
    output logic [7:0]  vdt_data,
    output logic        vdt_valid,
    input  logic        vdt_ready,
    output logic        timer_irq
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned PW    = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    localparam logic [PW-1:0]      PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]      PRESC_ZERO = '0;
    localparam logic [PW-1:0]      PRESC_ONE  = PW'(1);
    localparam logic [FIFO_AW-1:0] PTR_ZERO   = '0;
    localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]   CNT_ZERO   = '0;
    localparam logic [FIFO_AW:0]   CNT_ONE    = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW:0]   CNT_FULL   = (FIFO_AW + 1)'(DEPTH);

    localparam logic [7:0] ADDR_GPIO_OUT = 8'h10;
    localparam logic [7:0] ADDR_GPIO_IN  = 8'h11;
    localparam logic [7:0] ADDR_TICK     = 8'h12;
    localparam logic [7:0] ADDR_TCTRL    = 8'h13;
    localparam logic [7:0] ADDR_VDT      = 8'h14;
    localparam logic [7:0] ADDR_VSTAT    = 8'h15;
    localparam logic [7:0] ADDR_CMP      = 8'h16;
    localparam logic [7:0] ADDR_ID       = 8'h17;

    logic [15:0]        iordt_r;
    logic [15:0]        gpio_out_r;
    logic [15:0]        sync1_r;
    logic [15:0]        sync2_r;
    logic [15:0]        tick_cnt_r;
    logic [15:0]        cmp_r;
    logic [PW-1:0]      presc_r;
    logic               enable_r;
    logic               irq_r;
    logic               overflow_r;
    logic [7:0]         mem_r [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_r;
    logic [FIFO_AW-1:0] rd_ptr_r;
    logic [FIFO_AW:0]   count_r;

    logic               wr_gpio_s;
    logic               wr_tick_s;
    logic               wr_tctrl_s;
    logic               wr_vstat_s;
    logic               wr_cmp_s;
    logic               push_s;
    logic               pop_s;
    logic               full_s;
    logic               push_ok_s;
    logic               tick_s;
    logic [15:0]        tick_inc_s;
    logic               irq_set_s;
    logic               irq_clr_s;
    logic [15:0]        status_s;
    logic [15:0]        rd_mux_s;

    assign wr_gpio_s  = iow && (ioad == ADDR_GPIO_OUT);
    assign wr_tick_s  = iow && (ioad == ADDR_TICK);
    assign wr_tctrl_s = iow && (ioad == ADDR_TCTRL);
    assign wr_vstat_s = iow && (ioad == ADDR_VSTAT);
    assign wr_cmp_s   = iow && (ioad == ADDR_CMP);
    assign push_s     = iow && (ioad == ADDR_VDT);

    assign vdt_valid  = (count_r != CNT_ZERO);
    assign vdt_data   = mem_r[rd_ptr_r];
    assign pop_s      = vdt_valid && vdt_ready;
    assign full_s     = (count_r == CNT_FULL);
    // A full FIFO still takes the byte when the head leaves in the same cycle.
    assign push_ok_s  = push_s && (!full_s || pop_s);

    assign tick_s     = enable_r && (presc_r == PRESC_LAST);
    assign tick_inc_s = tick_cnt_r + 16'd1;
    assign irq_set_s  = tick_s && (tick_inc_s == cmp_r);
    assign irq_clr_s  = wr_tctrl_s && iowdt[15];

    assign status_s   = {8'h00, overflow_r, 3'b000, 4'(count_r)};

    assign iordt      = iordt_r;
    assign gpio_out   = gpio_out_r;
    assign timer_irq  = irq_r;

    // Read data multiplexer, selected by the bus address.
    always_comb begin
        rd_mux_s = 16'h0000;
        case (ioad)
            ADDR_GPIO_OUT: rd_mux_s = gpio_out_r;
            ADDR_GPIO_IN:  rd_mux_s = sync2_r;
            ADDR_TICK:     rd_mux_s = tick_cnt_r;
            ADDR_TCTRL:    rd_mux_s = {irq_r, 14'b0, enable_r};
            ADDR_VDT:      rd_mux_s = status_s;
            ADDR_VSTAT:    rd_mux_s = status_s;
            ADDR_CMP:      rd_mux_s = cmp_r;
            ADDR_ID:       rd_mux_s = DEV_ID;
            default:       rd_mux_s = 16'h0000;
        endcase
    end

    // Read data register, GPIO output register and input synchroniser.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            iordt_r    <= 16'h0000;
            gpio_out_r <= 16'h0000;
            sync1_r    <= 16'h0000;
            sync2_r    <= 16'h0000;
            cmp_r      <= 16'hFFFF;
        end else begin
            sync1_r <= gpio_in;
            sync2_r <= sync1_r;
            if (ior) begin
                iordt_r <= rd_mux_s;
            end
            if (wr_gpio_s) begin
                gpio_out_r <= iowdt;
            end
            if (wr_cmp_s) begin
                cmp_r <= iowdt;
            end
        end
    end

    // Prescaler, tick counter and sticky compare flag; bus writes beat ticks.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            presc_r    <= PRESC_ZERO;
            tick_cnt_r <= 16'h0000;
            enable_r   <= 1'b0;
            irq_r      <= 1'b0;
        end else begin
            if (wr_tick_s) begin
                tick_cnt_r <= iowdt;
                presc_r    <= PRESC_ZERO;
            end else if (tick_s) begin
                tick_cnt_r <= tick_inc_s;
                presc_r    <= PRESC_ZERO;
            end else if (enable_r) begin
                presc_r <= presc_r + PRESC_ONE;
            end
            if (wr_tctrl_s) begin
                enable_r <= iowdt[0];
            end
            if (irq_set_s) begin
                irq_r <= 1'b1;
            end else if (irq_clr_s) begin
                irq_r <= 1'b0;
            end
        end
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            overflow_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            if (push_s && !push_ok_s) begin
                overflow_r <= 1'b1;
            end else if (wr_vstat_s) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // FIFO storage; reset only discards it through the pointers.
    always_ff @(posedge CLOCK) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= iowdt[7:0];
        end
    end

endmodule

// File: tb/tb_io_resp.sv
// Directed bench for io_resp (PRESCALE=4): vector table plus FIFO, timer
// and reset sequences.
module tb_io_resp;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic [7:0]  ioad;
    logic [15:0] iowdt;
    logic        ior;
    logic        iow;
    logic [15:0] iordt;
    logic [15:0] gpio_in;
    logic [15:0] gpio_out;
    logic [7:0]  vdt_data;
    logic        vdt_valid;
    logic        vdt_ready;
    logic        timer_irq;

    int tests = 0;
    int fails = 0;

    io_resp #(.PRESCALE(4), .FIFO_AW(3), .DEV_ID(16'h7D41)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .ioad(ioad), .iowdt(iowdt),
        .ior(ior), .iow(iow), .iordt(iordt), .gpio_in(gpio_in),
        .gpio_out(gpio_out), .vdt_data(vdt_data), .vdt_valid(vdt_valid),
        .vdt_ready(vdt_ready), .timer_irq(timer_irq)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [7:0]  ad;
        logic [15:0] wd;
        logic        r;
        logic        w;
        logic        rdy;
        logic [15:0] e_rd;
        logic [15:0] e_go;
        logic        e_v;
        logic [7:0]  e_d;
    } vec_t;

    vec_t vecs[24];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus cycle: drive, let the edge happen, leave outputs for sampling.
    task automatic cyc(input logic [7:0] ad, input logic [15:0] wd,
                       input logic r, input logic w, input logic rdy);
        ioad = ad; iowdt = wd; ior = r; iow = w; vdt_ready = rdy;
        @(posedge CLOCK);
        #1;
        ior = 1'b0; iow = 1'b0; vdt_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(8'h00, 16'h0000, 1'b0, 1'b0, 1'b0);
    endtask

    logic [7:0] drain_exp [8];

    initial begin
        //            ad     wd        r     w     rdy   e_rd      e_go      e_v   e_d
        vecs[0]  = '{8'h17, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h7D41, 16'h0000, 1'b0, 8'h00};
        vecs[1]  = '{8'h14, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 8'h00};
        vecs[2]  = '{8'h10, 16'hA5C3, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hA5C3, 1'b0, 8'h00};
        vecs[3]  = '{8'h10, 16'h0000, 1'b1, 1'b0, 1'b0, 16'hA5C3, 16'hA5C3, 1'b0, 8'h00};
        vecs[4]  = '{8'h42, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hA5C3, 1'b0, 8'h00};
        vecs[5]  = '{8'h11, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h1234, 16'hA5C3, 1'b0, 8'h00};
        vecs[6]  = '{8'h14, 16'h0048, 1'b0, 1'b1, 1'b0, 16'h1234, 16'hA5C3, 1'b1, 8'h48};
        vecs[7]  = '{8'h14, 16'h0049, 1'b0, 1'b1, 1'b0, 16'h1234, 16'hA5C3, 1'b1, 8'h48};
        vecs[8]  = '{8'h15, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0002, 16'hA5C3, 1'b1, 8'h48};
        vecs[9]  = '{8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0002, 16'hA5C3, 1'b1, 8'h49};
        vecs[10] = '{8'h14, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0001, 16'hA5C3, 1'b1, 8'h49};
        vecs[11] = '{8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0001, 16'hA5C3, 1'b0, 8'h00};
        vecs[12] = '{8'h14, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 16'hA5C3, 1'b0, 8'h00};
        vecs[13] = '{8'h10, 16'h5A5A, 1'b1, 1'b1, 1'b0, 16'hA5C3, 16'h5A5A, 1'b0, 8'h00};
        vecs[14] = '{8'h16, 16'h0003, 1'b0, 1'b1, 1'b0, 16'hA5C3, 16'h5A5A, 1'b0, 8'h00};
        vecs[15] = '{8'h16, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0003, 16'h5A5A, 1'b0, 8'h00};
        vecs[16] = '{8'h13, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h5A5A, 1'b0, 8'h00};
        vecs[17] = '{8'h12, 16'h1234, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h5A5A, 1'b0, 8'h00};
        vecs[18] = '{8'h12, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h5A5A, 1'b0, 8'h00};
        vecs[19] = '{8'h12, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h5A5A, 1'b0, 8'h00};
        vecs[20] = '{8'h12, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h5A5A, 1'b0, 8'h00};
        vecs[21] = '{8'h00, 16'hFFFF, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h5A5A, 1'b0, 8'h00};
        vecs[22] = '{8'h17, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h7D41, 16'h5A5A, 1'b0, 8'h00};
        vecs[23] = '{8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h5A5A, 1'b0, 8'h00};

        RESET = 1'b1; ioad = 8'h00; iowdt = 16'h0000; ior = 1'b0; iow = 1'b0;
        vdt_ready = 1'b0; gpio_in = 16'h0000;
        @(posedge CLOCK);
        #1;
        chk("reset iordt", iordt, 16'h0000);
        chk("reset gpio_out", gpio_out, 16'h0000);
        chk("reset vdt_valid", {15'b0, vdt_valid}, 16'h0000);
        chk("reset timer_irq", {15'b0, timer_irq}, 16'h0000);
        idle(1);
        RESET = 1'b0;
        gpio_in = 16'h1234;

        for (int i = 0; i < 24; i++) begin
            cyc(vecs[i].ad, vecs[i].wd, vecs[i].r, vecs[i].w, vecs[i].rdy);
            chk($sformatf("vec%0d iordt", i), iordt, vecs[i].e_rd);
            chk($sformatf("vec%0d gpio_out", i), gpio_out, vecs[i].e_go);
            chk($sformatf("vec%0d vdt_valid", i), {15'b0, vdt_valid}, {15'b0, vecs[i].e_v});
            if (vecs[i].e_v)
                chk($sformatf("vec%0d vdt_data", i), {8'h00, vdt_data}, {8'h00, vecs[i].e_d});
        end

        // FIFO overflow: nine pushes, the ninth (0x38) is dropped.
        for (int i = 0; i < 9; i++) cyc(8'h14, 16'h0030 + 16'(i), 1'b0, 1'b1, 1'b0);
        cyc(8'h14, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("full status", iordt, 16'h0088);
        chk("full head", {8'h00, vdt_data}, 16'h0030);
        cyc(8'h15, 16'h1234, 1'b0, 1'b1, 1'b0);
        cyc(8'h15, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("ovf cleared status", iordt, 16'h0008);
        cyc(8'h14, 16'h0039, 1'b0, 1'b1, 1'b1);
        cyc(8'h14, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("push+pop on full status", iordt, 16'h0008);
        drain_exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h39};
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d valid", i), {15'b0, vdt_valid}, 16'h0001);
            chk($sformatf("drain%0d data", i), {8'h00, vdt_data}, {8'h00, drain_exp[i]});
            cyc(8'h00, 16'h0000, 1'b0, 1'b0, 1'b1);
        end
        chk("drained valid", {15'b0, vdt_valid}, 16'h0000);

        // Timer: cmp=3 already, tick_cnt=0; enable and count three ticks.
        cyc(8'h13, 16'h0001, 1'b0, 1'b1, 1'b0);
        idle(11);
        chk("irq before match", {15'b0, timer_irq}, 16'h0000);
        idle(1);
        chk("irq at match", {15'b0, timer_irq}, 16'h0001);
        cyc(8'h12, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("tick_cnt at match", iordt, 16'h0003);
        cyc(8'h13, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("tctrl read", iordt, 16'h8001);
        cyc(8'h13, 16'h8001, 1'b0, 1'b1, 1'b0);
        chk("irq cleared", {15'b0, timer_irq}, 16'h0000);
        idle(1);
        cyc(8'h12, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("tick_cnt continues", iordt, 16'h0004);
        cyc(8'h12, 16'hFFFF, 1'b0, 1'b1, 1'b0);
        idle(3);
        cyc(8'h12, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("tick_cnt before wrap", iordt, 16'hFFFF);
        cyc(8'h12, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("tick_cnt wrapped", iordt, 16'h0000);

        // Reset mid-operation: irq set, three bytes queued, timer running.
        cyc(8'h12, 16'h0002, 1'b0, 1'b1, 1'b0);
        cyc(8'h14, 16'h0041, 1'b0, 1'b1, 1'b0);
        cyc(8'h14, 16'h0042, 1'b0, 1'b1, 1'b0);
        cyc(8'h14, 16'h0043, 1'b0, 1'b1, 1'b0);
        cyc(8'h17, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("pre-reset irq", {15'b0, timer_irq}, 16'h0001);
        chk("pre-reset head", {8'h00, vdt_data}, 16'h0041);
        RESET = 1'b1;
        idle(1);
        RESET = 1'b0;
        chk("mid reset iordt", iordt, 16'h0000);
        chk("mid reset vdt_valid", {15'b0, vdt_valid}, 16'h0000);
        chk("mid reset irq", {15'b0, timer_irq}, 16'h0000);
        chk("mid reset gpio_out", gpio_out, 16'h0000);
        idle(5);
        cyc(8'h12, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("post reset tick_cnt", iordt, 16'h0000);
        cyc(8'h16, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("post reset cmp", iordt, 16'hFFFF);
        cyc(8'h15, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("post reset status", iordt, 16'h0000);
        cyc(8'h13, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("post reset tctrl", iordt, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/io_resp.md
Name: io_resp

Overview:
- I/O-bus responder on the CPU's external port: consumes ioad/iowdt/ior/iow strobes and returns iordt.
- Hosts four functions: a GPIO port, a millisecond tick timer with compare flag, an 8-entry character FIFO feeding the video text display (VDT, address 0x14), and an ID register.
- Sits beside the CPU core; the VDT consumer pops characters through a valid/ready handshake.

Parameters:
- PRESCALE, 50000, CLOCK cycles per timer tick (1 ms at 50 MHz); must be ≥ 2.
- FIFO_AW, 3, log2 of VDT FIFO depth (8 entries).
- DEV_ID, 16'h7D41, constant returned at address 0x17.

Ports:
- CLOCK  in  1  system clock, all logic on rising edge.
- RESET  in  1  synchronous, active-high.
- ioad  in  8  I/O address, valid when ior or iow is high.
- iowdt  in  16  write data, valid with iow.
- ior  in  1  one-cycle read strobe.
- iow  in  1  one-cycle write strobe.
- iordt  out  16  registered read data.
- gpio_in  in  16  asynchronous external inputs.
- gpio_out  out  16  GPIO output register.
- vdt_data  out  8  FIFO head character.
- vdt_valid  out  1  FIFO non-empty.
- vdt_ready  in  1  consumer accepts head this cycle.
- timer_irq  out  1  sticky compare-match flag.

Behaviour:
- Reset: iordt=0, gpio_out=0, FIFO empty (vdt_valid=0), tick_cnt=0, prescaler=0, enable=0, cmp=16'hFFFF, timer_irq=0, overflow=0, gpio sync flops=0.
- Clock and reset: reset is RESET, synchronous, active-high; clock is CLOCK.

Address map (R = read, W = write):
- 0x10 R/W gpio_out.
- 0x11 R gpio_in, after a 2-flop synchroniser.
- 0x12 R tick_cnt. W loads tick_cnt=iowdt and clears the prescaler.
- 0x13 R {timer_irq, 14'b0, enable}. W: enable=iowdt[0]; iowdt[15]=1 clears timer_irq.
- 0x14 W pushes iowdt[7:0] into the FIFO. R returns {8'b0, overflow, 3'b0, count[3:0]}.
- 0x15 R same status as 0x14. W of any value clears overflow.
- 0x16 R/W cmp.
- 0x17 R DEV_ID.
- All other addresses (including 0x00–0x03): reads return 0, writes are ignored.

Read timing:
- On a cycle with ior=1, iordt takes the mux(ioad) value at that clock edge.
- iordt holds until the next ior.
- Latency is 1 cycle; the CPU samples on its repeated instruction execution, ≥1 cycle later.
- Reads have no side effects.

Write timing:
- The register update is visible on the edge following iow.
- If ior and iow are high in the same cycle, both act: the read returns the pre-write value.

FIFO:
- Depth 2^FIFO_AW; read/write pointers are FIFO_AW bits and wrap; count is FIFO_AW+1 bits.
- vdt_valid = (count != 0). vdt_data = mem[rd_ptr], combinational from the register array.
- Pop when vdt_valid && vdt_ready.
- Push when full: the byte is dropped and overflow is set (sticky), unless a pop happens in the same cycle. In that case the push is accepted and count is unchanged.
- Simultaneous push and pop when not full: count is unchanged and both pointers advance.
- vdt_ready while empty: no effect.

Timer:
- When enable=1, the prescaler counts 0..PRESCALE-1.
- On wrap, tick_cnt increments by 1 (16-bit, FFFF→0000).
- When enable=0, both prescaler and tick_cnt hold.
- A 0x12 write on the same cycle as a tick: the write value wins.
- timer_irq is set when enable=1 and tick_cnt transitions into a value equal to cmp (checked on the incremented value). It stays set until cleared by a 0x13 write with bit15=1. Set wins over clear in the same cycle.

Reset mid-operation: everything returns to reset values on the next edge; FIFO contents are discarded.

Test Plan:
- Reset, then ior@0x17 → iordt=16'h7D41 one cycle later; ior@0x42 → iordt=0; ior@0x14 → 16'h0000.
- iow@0x10 data 16'hA5C3 → gpio_out=A5C3 next cycle. gpio_in=16'h1234 applied, wait 3 cycles, ior@0x11 → 16'h1234.
- Push 'H','I' via iow@0x14, hold vdt_ready=0 → vdt_valid=1, vdt_data=8'h48, status count=2. Pulse vdt_ready 1 cycle → vdt_data=8'h49, count=1.
- Push 9 bytes 0x30..0x38 with vdt_ready=0 → count=8, overflow=1 (status 16'h0088), 0x38 lost. Write 0x15 → status 16'h0008. Push on full with vdt_ready=1 same cycle → accepted, count stays 8.
- PRESCALE=4 build: write cmp=3, enable=1 → tick_cnt=3 after 12 cycles, timer_irq=1. iow@0x13 data 16'h8001 → irq cleared, counting continues. iow@0x12 data 16'hFFFF → wraps to 0 after 4 cycles.
- Assert RESET with 3 bytes queued and timer running → vdt_valid=0, tick_cnt=0, iordt=0, timer_irq=0 next edge.
